rapcore_wb_master: RTL and testbench
====================================

// Module: rapcore_wb_master
// PURPOSE
//  Wishbone classic-cycle initiator: turns a valid/ready command stream into single
//  read/write bus cycles and returns one response per command. It drives the slave
//  port of the user project and test harnesses with the same bus the management SoC
//  presents. Commands are buffered in a FIFO. A watchdog ends cycles the slave never
//  acknowledges.
// PARAMETERS
//  CMD_DEPTH  4   command FIFO depth; power of two, >=2
//  TIMEOUT    64  cycles to wait for wbm_ack_i before erroring; 0 = wait forever
// PORTS
//  wb_clk_i     in   1   single clock; all logic is on the rising edge
//  wb_rst_ni    in   1   asynchronous active-low reset
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   command accepted when cmd_valid&&cmd_ready
//  cmd_we       in   1   1=write, 0=read
//  cmd_sel      in   4   byte selects
//  cmd_adr      in   32  byte address
//  cmd_dat      in   32  write data
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   response consumed when rsp_valid&&rsp_ready
//  rsp_dat      out  32  read data; 0 for writes and timeouts
//  rsp_err      out  1   1 = cycle timed out
//  busy         out  1   FSM not IDLE or FIFO not empty
//  wbm_cyc_o    out  1   Wishbone cycle
//  wbm_stb_o    out  1   Wishbone strobe; always equal to wbm_cyc_o
//  wbm_we_o     out  1   Wishbone write enable
//  wbm_sel_o    out  4   Wishbone byte selects
//  wbm_adr_o    out  32  Wishbone address
//  wbm_dat_o    out  32  Wishbone write data
//  wbm_ack_i    in   1   Wishbone acknowledge
//  wbm_dat_i    in   32  Wishbone read data
// BEHAVIOUR
//  - Reset (async assert, sync release): every registered output is 0; FIFO empty;
//    FSM in IDLE; watchdog cleared. cmd_ready = !fifo_full, so it is 1 right after reset.
//  - FIFO: push on cmd handshake; push is blocked when full (no pass-through).
//    Pop happens only in IDLE. Order is strict FIFO.
//  - FSM IDLE -> BUS when FIFO is non-empty. On that edge: pop the entry, register
//    it onto wbm_*_o, set cyc=stb=1, clear the watchdog.
//  - Latency: a command accepted at edge N, into an empty FIFO with the FSM idle,
//    has cyc/stb high after edge N+2.
//  - BUS: adr/dat/sel/we are held stable.
//    - On an edge with wbm_ack_i=1: cyc=stb=0; rsp_dat = we ? 0 : wbm_dat_i;
//      rsp_err=0; rsp_valid=1; go to RESP.
//    - Otherwise the watchdog increments. When TIMEOUT!=0 and the count reaches
//      TIMEOUT (cyc has been high TIMEOUT cycles): cyc=stb=0, rsp_dat=0, rsp_err=1,
//      rsp_valid=1; go to RESP.
//    - Ack and timeout on the same edge: ack wins.
//  - RESP: rsp_valid and its data are held until rsp_ready; then rsp_valid=0 and
//    the FSM goes to IDLE. This guarantees at least one idle cycle with cyc low
//    between transactions.
//  - wbm_ack_i outside BUS is ignored. wbm_dat_o/adr/sel/we keep their last values
//    when idle.
//  - Watchdog width is $clog2(TIMEOUT+1); it saturates and never wraps.
//  - FIFO pointers are $clog2(CMD_DEPTH)+1 bits; the MSB distinguishes full from empty.
//    Wrap-around is natural.
//  - Reset mid-transaction: cyc/stb/rsp_valid drop immediately. FIFO contents and
//    any pending response are discarded.
// STRUCTURE
//  - Package rapcore_wb_pkg: WB_AW=32, WB_DW=32, WB_SW=4; FSM state localparams
//    (IDLE=2'd0, BUS=2'd1, RESP=2'd2); command struct/width constant
//    CMD_W = 1+4+32+32 = 69.
//  - Sub-module rapcore_sync_fifo (WIDTH=CMD_W, DEPTH=CMD_DEPTH): async active-low
//    reset, full/empty flags, registered read data, reusable elsewhere.
//  - Top level: FSM, watchdog and response registers.
// TESTING
//  1. Write adr=0x3000_0004, dat=0xA5A5_0001, sel=F; slave acks on the 3rd cycle of
//     cyc -> cyc/stb high exactly 3 cycles with bus fields stable;
//     rsp_valid=1, rsp_err=0, rsp_dat=0.
//  2. Read adr=0x3000_0008; slave returns 0x1234_5678 with ack ->
//     rsp_dat=0x1234_5678, rsp_err=0; cyc low the cycle after ack.
//  3. TIMEOUT=16, slave never acks -> cyc drops after exactly 16 high cycles;
//     rsp_err=1, rsp_dat=0; the next queued command then issues normally.
//  4. rsp_ready=0, offer 8 commands with CMD_DEPTH=4 -> 5 accepted (1 in flight
//     + 4 queued), cmd_ready=0; release rsp_ready -> all 5 complete in order,
//     each separated by >=1 idle cycle.
//  5. Assert wb_rst_ni low while in BUS -> cyc/stb/rsp_valid go 0 without a clock
//     edge; after release: cmd_ready=1, busy=0, no stale response.
//  6. TIMEOUT=16 with ack arriving on the 16th cycle -> rsp_err=0 and read data
//     captured (ack beats timeout).

Source files
------------

// File: rtl/rapcore_wb_pkg.sv
// Shared types and constants for the Wishbone classic-cycle initiator.
package rapcore_wb_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  // Initiator FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // One queued bus command
  typedef struct packed {
    logic             we;
    logic [WB_SW-1:0] sel;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
  } wb_cmd_t;

  localparam int unsigned CMD_W = 1 + WB_SW + WB_AW + WB_DW;

endpackage

// File: rtl/rapcore_sync_fifo.sv
// Synchronous FIFO with full/empty flags and registered read data.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   wr_en, wr_data   push (ignored when full)
//   rd_en, rd_data   pop (ignored when empty); rd_data valid the cycle after rd_en
//   full, empty      occupancy flags derived from the pointers
module rapcore_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_fire;
  logic             rd_fire;

  // Extra pointer MSB tells a full buffer from an empty one
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and read register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_fire) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/rapcore_wb_master.sv
// Wishbone classic-cycle initiator: valid/ready commands in, one single-beat
// bus cycle per command, one response per command out. A watchdog ends
// cycles the slave never acknowledges.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   cmd_*                        command stream (valid/ready)
//   rsp_*                        response stream (valid/ready), rsp_err = timeout
//   busy                         work in flight or queued
//   wbm_*_o / wbm_ack_i, dat_i   Wishbone initiator port
module rapcore_wb_master
  import rapcore_wb_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_SW-1:0] cmd_sel,
  input  logic [WB_AW-1:0] cmd_adr,
  input  logic [WB_DW-1:0] cmd_dat,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             busy,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [WB_DW-1:0] wbm_dat_i
);

  localparam int unsigned WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  wb_cmd_t          cmd_in;
  wb_cmd_t          fifo_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_rd;

  wb_state_e        state_q, state_d;
  logic             fetch_q, fetch_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             wd_expired_c;

  logic             cyc_d;
  logic             we_d;
  logic [WB_SW-1:0] sel_d;
  logic [WB_AW-1:0] adr_d;
  logic [WB_DW-1:0] dat_d;
  logic             rsp_valid_d;
  logic             rsp_err_d;
  logic [WB_DW-1:0] rsp_dat_d;

  assign cmd_in = '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat};

  rapcore_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .wr_en   (cmd_valid),
    .wr_data (cmd_in),
    .rd_en   (fifo_rd),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  // fetch_q covers the entry already popped but not yet on the bus
  assign busy      = (state_q != IDLE) || !fifo_empty || fetch_q;

  // Watchdog fires on the edge that completes TIMEOUT high cycles of cyc
  assign wd_expired_c = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    fetch_d     = fetch_q;
    wd_d        = wd_q;
    fifo_rd     = 1'b0;
    cyc_d       = wbm_cyc_o;
    we_d        = wbm_we_o;
    sel_d       = wbm_sel_o;
    adr_d       = wbm_adr_o;
    dat_d       = wbm_dat_o;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_dat_d   = rsp_dat;

    case (state_q)
      IDLE: begin
        // Registered FIFO read: pop one cycle, launch the cycle the next
        if (fetch_q) begin
          fetch_d = 1'b0;
          cyc_d   = 1'b1;
          we_d    = fifo_q.we;
          sel_d   = fifo_q.sel;
          adr_d   = fifo_q.adr;
          dat_d   = fifo_q.dat;
          wd_d    = '0;
          state_d = BUS;
        end else if (!fifo_empty) begin
          fifo_rd = 1'b1;
          fetch_d = 1'b1;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wd_expired_c) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wd_q != '1) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      fetch_q   <= 1'b0;
      wd_q      <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      state_q   <= state_d;
      fetch_q   <= fetch_d;
      wd_q      <= wd_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= cyc_d;
      wbm_we_o  <= we_d;
      wbm_sel_o <= sel_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_dat   <= rsp_dat_d;
    end
  end

endmodule

// File: tb/tb_rapcore_wb_master.sv
// Scoreboard bench for rapcore_wb_master: commands carry a slave plan
// (ack delay, read data); the reference model predicts the response and
// the number of cycles cyc stays high.
`timescale 1ns/1ps
module tb_rapcore_wb_master;
  import rapcore_wb_pkg::*;

  localparam int unsigned TMO   = 16;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  always #5 clk = ~clk;

  rapcore_wb_master #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .busy(busy),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  // delay = cyc cycle on which the slave acks; 0 = never
  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int unsigned delay;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  plan_t plan_q[$];
  rsp_t  exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    rr_mode = 0;  // 0 random rsp_ready, 1 hold low, 2 hold high

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit acked(input plan_t p);
    return (p.delay != 0) && (p.delay <= TMO);
  endfunction

  function automatic rsp_t model(input plan_t p);
    rsp_t r;
    r.err = !acked(p);
    r.dat = (acked(p) && !p.we) ? p.rdata : 32'h0;
    return r;
  endfunction

  function automatic int unsigned exp_high(input plan_t p);
    return acked(p) ? p.delay : TMO;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    int unsigned r;
    p.we = 1'($urandom); p.sel = 4'($urandom);
    p.adr = $urandom; p.dat = $urandom; p.rdata = $urandom;
    r = $urandom_range(0, 9);
    case (r)
      6: p.delay = 15;
      7: p.delay = 16;
      8: p.delay = 17;
      9: p.delay = 0;
      default: p.delay = $urandom_range(1, 4);
    endcase
    return p;
  endfunction

  function automatic plan_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input int unsigned delay, input logic [31:0] rdata);
    plan_t p;
    p.we = we; p.sel = 4'hF; p.adr = adr; p.dat = dat; p.delay = delay; p.rdata = rdata;
    return p;
  endfunction

  task automatic enqueue(input plan_t p);
    plan_q.push_back(p);
    exp_q.push_back(model(p));
  endtask

  task automatic drive(input plan_t p);
    cmd_we = p.we; cmd_sel = p.sel; cmd_adr = p.adr; cmd_dat = p.dat;
    cmd_valid = 1'b1;
  endtask

  // Called at a negedge; returns at a negedge
  task automatic send(input plan_t p);
    int g = 0;
    drive(p);
    while (!cmd_ready && g < 500) begin @(negedge clk); g++; end
    if (!cmd_ready) begin
      check("cmd_accept", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    enqueue(p);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 3000) begin @(negedge clk); g++; end
    check("drain_busy", busy, 0);
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Response monitor: picks rsp_ready for the next edge, then scores a handshake
  always @(negedge clk) begin : mon
    rsp_t e;
    if (rr_mode == 0) rsp_ready = ($urandom_range(0, 2) != 0);
    else              rsp_ready = (rr_mode == 2);
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("rsp_err", rsp_err, e.err);
        check("rsp_dat", rsp_dat, e.dat);
      end
    end
  end

  // Slave model: checks bus fields each cyc cycle and the cyc high length
  always @(negedge clk) begin : slv
    static int unsigned cnt = 0;
    static plan_t cur = '{default: '0};
    if (!rst_n) begin
      cnt = 0;
      wbm_ack_i = 1'b0;
    end else if (wbm_cyc_o) begin
      if (cnt == 0) begin
        if (plan_q.size() == 0) begin
          check("plan_avail", plan_q.size(), 1);
          cur = '{default: '0};
        end else cur = plan_q.pop_front();
      end
      cnt++;
      check("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
      check("bus_fields", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
            {cur.we, cur.sel, cur.adr, cur.dat});
      wbm_ack_i = (cnt == cur.delay);
      wbm_dat_i = wbm_ack_i ? cur.rdata : $urandom;
    end else begin
      if (cnt != 0) begin
        check("cyc_high_cycles", cnt, exp_high(cur));
        cnt = 0;
      end
      // Acks outside a cycle must be ignored
      wbm_ack_i = ($urandom_range(0, 3) == 0);
      wbm_dat_i = $urandom;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    plan_t p;
    int acc;
    int g;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    rr_mode = 2;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Write acked on 3rd cycle, with issue latency
    p = mk(1'b1, 32'h3000_0004, 32'hA5A5_0001, 3, 32'hDEAD_BEEF);
    drive(p);
    check("t1_cmd_ready", cmd_ready, 1);
    enqueue(p);
    @(negedge clk); cmd_valid = 1'b0;
    check("lat_edge_n", wbm_cyc_o, 0);
    @(negedge clk);
    check("lat_edge_n1", wbm_cyc_o, 0);
    @(negedge clk);
    check("lat_edge_n2", wbm_cyc_o, 1);
    drain();

    // Read with data
    send(mk(1'b0, 32'h3000_0008, 32'h0, 2, 32'h1234_5678));
    drain();

    // Timeout, then a normal command behind it
    send(mk(1'b0, 32'h3000_0010, 32'h0, 0, 32'h5555_AAAA));
    send(mk(1'b1, 32'h3000_0014, 32'h0BAD_F00D, 2, 32'h0));
    drain();

    // Ack on the last allowed cycle, then one cycle too late
    send(mk(1'b0, 32'h3000_0018, 32'h0, 16, 32'hCAFE_F00D));
    send(mk(1'b0, 32'h3000_001C, 32'h0, 17, 32'h7777_1111));
    drain();

    // Random traffic with random response backpressure
    rr_mode = 0;
    repeat (60) send(rand_plan());
    rr_mode = 2;
    drain();

    // Response stalled: 1 in flight plus DEPTH queued
    rr_mode = 1;
    acc = 0;
    p = mk(1'b0, 32'h4000_0000, 32'h0, 1, $urandom);
    repeat (60) begin
      if (acc < 8) begin
        drive(p);
        if (cmd_ready) begin
          enqueue(p);
          acc++;
          p = mk(1'b0, 32'h4000_0000 + 32'(acc * 4), 32'h0, 1, $urandom);
        end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("bp_accepted", acc, DEPTH + 1);
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_rsp_valid", rsp_valid, 1);
    rr_mode = 2;
    drain();

    // Reset while a cycle is on the bus
    send(mk(1'b0, 32'h5000_0000, 32'h0, 0, 32'h0));
    g = 0;
    while (!wbm_cyc_o && g < 50) begin @(negedge clk); g++; end
    check("rst_mid_in_bus", wbm_cyc_o, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_cyc", wbm_cyc_o, 0);
    check("rst_mid_stb", wbm_stb_o, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    plan_q.delete();
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("post_rst_no_rsp", rsp_valid, 0);
    check("post_rst_no_cyc", wbm_cyc_o, 0);
    send(mk(1'b1, 32'h5000_0004, 32'h1357_9BDF, 3, 32'h0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
